// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage.
//
// Owns the PC, issues in-order requests to the instruction memory, and keeps
// the returned words in a small FIFO. Each FIFO entry carries its PC. Decode
// takes entries through a valid/stall handshake. A redirect from execute
// reloads the PC, flushes the FIFO and drops every response still in flight.
//
// Ports
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   imem_req_o / imem_addr_o      fetch request; address is held until imem_gnt_i
//   imem_gnt_i                    request accepted
//   imem_rvalid_i / imem_rdata_i  in-order response
//   redirect_valid_i / _pc_i      branch/jump/trap redirect
//   hazard_stall_i                decode cannot accept this cycle
//   instr_valid_o, instr_o,       instruction to decode and its PC
//   instr_pc_o
//   misalign_o                    only when FETCH_MISALIGN_CHK_EN is defined
//
// Optional feature (macro FETCH_MISALIGN_CHK_EN):
//   A redirect to a target that is not word aligned issues no fetch. It
//   presents one NOP that is flagged misaligned and tagged with the target PC.
//   When the macro is undefined, the low two bits of the target are cleared.
module fetch_unit #(
  parameter int              DATA_W     = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              imem_req_o,
  output logic [DATA_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  input  logic              redirect_valid_i,
  input  logic [DATA_W-1:0] redirect_pc_i,
  input  logic              hazard_stall_i,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic              misalign_o,
`endif
  output logic              instr_valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [DATA_W-1:0] instr_pc_o
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  // kill counts responses that are owed but doomed. Back-to-back redirects
  // under a slow memory stack up, so the counter gets extra headroom.
  localparam int KW = CW + 3;
  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

  logic [DATA_W-1:0] pc_q, last_pc_q, tgt;
  logic [DATA_W-1:0] instr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] pc_mem    [FIFO_DEPTH];
  logic [DATA_W-1:0] tag_mem   [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [CW-1:0]     count, outst, out_after;
  logic [KW-1:0]     kill, kill_after;
  logic [CW:0]       occ;
  logic              mis_q, fifo_valid, gnt_fire, push, pop, pop_fifo;
  logic              killing, pc_ok;

`ifdef FETCH_MISALIGN_CHK_EN
  assign tgt = redirect_pc_i;
`else
  assign tgt = redirect_pc_i & ~DATA_W'(3);
`endif

  // outst counts only live requests. Doomed responses are tracked in kill,
  // so they do not hold back issue after a redirect.
  assign occ        = (CW+1)'(count) + (CW+1)'(outst);
  assign pc_ok      = (pc_q[1:0] == 2'b00);
  assign imem_req_o = rst_ni && !redirect_valid_i && pc_ok &&
                      (occ < (CW+1)'(FIFO_DEPTH));
  assign imem_addr_o = pc_q;
  assign gnt_fire   = imem_req_o && imem_gnt_i;

  assign killing    = (kill != '0);
  assign push       = rst_ni && imem_rvalid_i && !killing && !redirect_valid_i;
  assign kill_after = kill - KW'(imem_rvalid_i && killing);
  assign out_after  = outst + CW'(gnt_fire) - CW'(imem_rvalid_i && !killing);

  assign fifo_valid    = (count != '0);
  assign instr_valid_o = fifo_valid || mis_q;
  assign instr_o       = fifo_valid ? instr_mem[rd_ptr] : NOP;
  assign instr_pc_o    = mis_q ? pc_q : (fifo_valid ? pc_mem[rd_ptr] : last_pc_q);
  assign pop           = instr_valid_o && !hazard_stall_i && !redirect_valid_i;
  assign pop_fifo      = pop && fifo_valid;

`ifdef FETCH_MISALIGN_CHK_EN
  assign misalign_o = mis_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni)               mis_q <= 1'b0;
    else if (redirect_valid_i) mis_q <= (tgt[1:0] != 2'b00);
    else if (pop)              mis_q <= 1'b0;
  end
`else
  assign mis_q = 1'b0;
`endif

  // Storage: no reset. Only slots that the pointers cover are ever read.
  always_ff @(posedge clk_i) begin
    if (gnt_fire) tag_mem[tag_wr] <= pc_q;
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata_i;
      pc_mem[wr_ptr]    <= tag_mem[tag_rd];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || redirect_valid_i) begin
      // Everything still in flight, counted after this cycle's response, is dropped.
      kill   <= kill_after + KW'(out_after);
      outst  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (!rst_ni) begin
        pc_q      <= RESET_PC;
        last_pc_q <= RESET_PC;
        tag_rd    <= '0;
        tag_wr    <= '0;
      end else begin
        pc_q   <= tgt;
        tag_rd <= tag_wr;   // tags of doomed requests are discarded
      end
    end else begin
      kill  <= kill_after;
      outst <= out_after;
      count <= count + CW'(push) - CW'(pop_fifo);
      if (gnt_fire) begin
        pc_q   <= pc_q + DATA_W'(4);
        tag_wr <= tag_wr + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        tag_rd <= tag_rd + 1'b1;
      end
      if (pop_fifo) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_pc_q <= pc_mem[rd_ptr];
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int          DW    = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n, req, gnt, rvalid, redirect, stall, valid;
  logic [31:0] addr, rdata, redirect_pc, instr, ipc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.DATA_W(DW), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .redirect_valid_i(redirect), .redirect_pc_i(redirect_pc),
    .hazard_stall_i(stall),
`ifdef FETCH_MISALIGN_CHK_EN
    .misalign_o(misalign),
`endif
    .instr_valid_o(valid), .instr_o(instr), .instr_pc_o(ipc)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model. Each request is stamped with an epoch. A reset or a
  // redirect starts a new epoch, and a response is kept only if its epoch
  // is still current. The decode-side queue holds the words that were kept.
  typedef struct { logic [31:0] a; int ep; int rdy; } mreq_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  mreq_t mq[$];
  ent_t  q[$];
  int epoch = 0, cyc = 0, pops = 0;
  logic [31:0] exp_pc = RPC, mis_pc = '0;
  bit mflag = 0;
  int p_gnt, p_rv, p_stall, p_redir, p_rst, lat_max;
  bit force_redir = 0;
  logic [31:0] force_tgt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  function automatic int live();
    int n = 0;
    foreach (mq[i]) if (mq[i].ep == epoch) n++;
    return n;
  endfunction

  task automatic step();
    logic  exp_req, exp_v;
    logic [31:0] raw;
    mreq_t r;
    @(negedge clk);
    rst_n    = ($urandom_range(999) >= p_rst);
    redirect = force_redir || ($urandom_range(99) < p_redir);
    raw      = force_redir ? force_tgt :
               ($urandom_range(3) == 0 ? 32'hFFFF_FFF8 : $urandom);
    redirect_pc = raw;
    force_redir = 0;
    stall  = ($urandom_range(99) < p_stall);
    rvalid = (mq.size() > 0) && (mq[0].rdy <= cyc) && ($urandom_range(99) < p_rv);
    rdata  = rvalid ? mem_word(mq[0].a) : $urandom;
    gnt    = 1'b0;
    #1;
    exp_req = rst_n && !redirect && (exp_pc[1:0] == 2'b00) && ((q.size() + live()) < DEPTH);
    chk("req", {31'b0, req}, {31'b0, exp_req});
    if (exp_req) chk("addr", addr, exp_pc);
    exp_v = mflag || (q.size() > 0);
    chk("valid", {31'b0, valid}, {31'b0, exp_v});
    if (mflag) begin
      chk("mis_instr", instr, NOP);
      chk("mis_pc", ipc, mis_pc);
    end else if (q.size() > 0) begin
      chk("instr", instr, q[0].instr);
      chk("ipc", ipc, q[0].pc);
    end
`ifdef FETCH_MISALIGN_CHK_EN
    chk("misalign", {31'b0, misalign}, {31'b0, mflag});
`endif
    gnt = req && exp_req && ($urandom_range(99) < p_gnt);
    // Model update for the coming rising edge.
    if (rvalid) r = mq.pop_front();
    if (!rst_n) begin
      epoch++; exp_pc = RPC; q.delete(); mflag = 0;
    end else if (redirect) begin
      epoch++; q.delete();
`ifdef FETCH_MISALIGN_CHK_EN
      exp_pc = raw; mflag = (raw[1:0] != 2'b00); mis_pc = raw;
`else
      exp_pc = raw & ~32'd3; mflag = 0;
`endif
    end else begin
      if (exp_v && !stall) begin
        if (mflag) mflag = 0; else void'(q.pop_front());
        pops++;
      end
      if (rvalid && r.ep == epoch) q.push_back('{mem_word(r.a), r.a});
      if (gnt) begin
        mq.push_back('{exp_pc, epoch, cyc + $urandom_range(1, lat_max)});
        exp_pc = exp_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic knobs(input int g, input int rv, input int st, input int rd, input int rs, input int lm);
    p_gnt = g; p_rv = rv; p_stall = st; p_redir = rd; p_rst = rs; lat_max = lm;
  endtask

  // Runs cycles until decode first sees a valid entry and checks its PC
  // (and optionally its word). Gives up after n cycles.
  task automatic first_out(input string tag, input logic [31:0] epc, input bit ci,
                           input logic [31:0] ei, input int n);
    bit seen = 0;
    for (int i = 0; i < n && !seen; i++) begin
      step();
      @(posedge clk); #1;
      if (valid) begin
        seen = 1;
        chk(tag, ipc, epc);
        if (ci) chk({tag, "_instr"}, instr, ei);
      end
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int p0;
    rst_n = 0; gnt = 0; rvalid = 0; rdata = '0; redirect = 0; redirect_pc = '0; stall = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_ipc", ipc, RPC);
    chk("rst_req", {31'b0, req}, 32'd0);

    // T1: streaming from reset
    knobs(100, 100, 0, 0, 0, 1);
    first_out("t1_first", 32'h0, 1, 32'h0050_0093, 10);
    run(10);

    // T2: long stall, then release
    knobs(100, 100, 100, 0, 0, 2);
    run(6);
    p0 = pops;
    knobs(100, 100, 0, 0, 0, 2);
    run(10);
    chk("t2_drain", {31'b0, pops > p0}, 32'd1);

    // T3: two requests in flight, then a redirect to 0x100
    knobs(100, 0, 100, 0, 0, 1);
    run(3);
    force_redir = 1; force_tgt = 32'h100;
    knobs(100, 100, 0, 0, 0, 1);
    first_out("t3_redir", 32'h100, 0, 32'h0, 20);

    // T4: grant held off for 3 cycles
    knobs(0, 100, 0, 0, 0, 1);
    run(3);
    knobs(100, 100, 0, 0, 0, 1);
    run(6);

    // T5: the PC wraps across 0xFFFF_FFFC
    force_redir = 1; force_tgt = 32'hFFFF_FFF8;
    first_out("t5_wrap", 32'hFFFF_FFF8, 1, mem_word(32'hFFFF_FFF8), 20);
    run(8);

    // Misaligned redirect target
    force_redir = 1; force_tgt = 32'h102;
    knobs(100, 100, 100, 0, 0, 1);
`ifdef FETCH_MISALIGN_CHK_EN
    first_out("t6_mis", 32'h102, 1, NOP, 4);
`else
    first_out("t6_align", 32'h100, 0, 32'h0, 20);
`endif
    run(4);
    knobs(100, 100, 0, 0, 0, 1);
    run(4);
    force_redir = 1; force_tgt = 32'h200;
    run(6);

    // Random mixes: redirects, stalls, backpressure, mid-run resets
    for (int ph = 0; ph < 8; ph++) begin
      knobs($urandom_range(30, 100), $urandom_range(50, 100), $urandom_range(0, 60),
            $urandom_range(0, 15), (ph % 3 == 2) ? 8 : 0, $urandom_range(1, 4));
      p0 = pops;
      run(300);
      chk("progress", {31'b0, pops > p0}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
